// File: rtl/upscale_line_sched.sv
// ---------------------------------------------------------------------------
// upscale_line_sched
//
// Frame-buffer read scheduler and ping-pong line-buffer controller for the
// 2x upscaler. One source line (SRC_W pixels) is prefetched from the shared
// single-port frame buffer into the fill bank while the display bank is
// replayed twice horizontally and twice vertically as 640x480 output.
// The camera writer and the prefetch share the frame-buffer port. The writer
// normally wins, but a fetch that has been refused MAX_WAIT times in a row
// takes the port.
//
// Ports
//   clk_25mhz              VGA pixel clock, the only clock
//   reset_n                synchronous active-low reset
//   drawX, drawY           raster position (0..799, 0..524)
//   wr_req/wr_addr/wr_data camera write request, held until wr_ack
//   wr_ack                 write performed this cycle (combinational)
//   fb_addr/fb_we/fb_wdata frame-buffer port
//   fb_rdata               frame-buffer read data, one cycle after address
//   pixel_R/G/B_in         pixel to the upscaler, one cycle after drawX/drawY
//   underrun               sticky: a line bank was needed before it was ready
// ---------------------------------------------------------------------------
module upscale_line_sched #(
    parameter int SRC_W    = 320,
    parameter int SRC_H    = 240,
    parameter int MAX_WAIT = 3
) (
    input  logic        clk_25mhz,
    input  logic        reset_n,
    input  logic [9:0]  drawX,
    input  logic [9:0]  drawY,
    input  logic        wr_req,
    input  logic [16:0] wr_addr,
    input  logic [11:0] wr_data,
    output logic        wr_ack,
    output logic [16:0] fb_addr,
    output logic        fb_we,
    output logic [11:0] fb_wdata,
    input  logic [11:0] fb_rdata,
    output logic [3:0]  pixel_R_in,
    output logic [3:0]  pixel_G_in,
    output logic [3:0]  pixel_B_in,
    output logic        underrun
);

    localparam int IDX_W  = $clog2(SRC_W);
    localparam int LINE_W = $clog2(SRC_H);

    localparam logic [9:0]       V_LAST      = 10'd524;              // last raster row
    localparam logic [9:0]       LAST_TRIG_Y = 10'(2 * (SRC_H - 2)); // fetches source line SRC_H-1
    localparam logic [9:0]       OUT_W       = 10'(2 * SRC_W);
    localparam logic [9:0]       OUT_H       = 10'(2 * SRC_H);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(SRC_W - 1);
    localparam logic [3:0]       WAIT_LIMIT  = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN
    } state_t;

    state_t state;
    state_t state_next;

    // Fetch bookkeeping
    logic [IDX_W-1:0]  fx;
    logic [LINE_W-1:0] fy;
    logic              fill_bank;
    logic [3:0]        wait_cnt;
    logic [1:0]        done;

    // Read pipeline tag: where the data returning next cycle belongs
    logic              tag_valid;
    logic              tag_bank;
    logic [IDX_W-1:0]  tag_idx;

    // Frame-buffer port hold registers (idle port keeps its last address)
    logic [16:0]       addr_hold;
    logic [11:0]       wdata_hold;

    // Trigger decode
    logic              trig;
    logic [LINE_W-1:0] trig_line;
    logic              line_late;

    // FSM outputs and arbitration
    logic              fetch_req;
    logic              fetch_done;
    logic              abandon;
    logic              grant_rd;
    logic              grant_wr;
    logic [16:0]       line_base;
    logic [16:0]       rd_addr;

    // Line buffer and display path
    logic [11:0]       bank0 [SRC_W];
    logic [11:0]       bank1 [SRC_W];
    logic              visible;
    logic [IDX_W-1:0]  disp_idx;
    logic [11:0]       rd0;
    logic [11:0]       rd1;
    logic              vis_q;
    logic              bank_q;
    logic [11:0]       pix;

    // -----------------------------------------------------------------------
    // Trigger decode. Row 524 preloads source line 0 for the next frame; each
    // even visible row up to LAST_TRIG_Y fetches the source line that the
    // following row pair will display.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first so that no path leaves it unassigned and infers a latch.
        trig      = 1'b0;
        trig_line = '0;
        if (drawX == 10'd0) begin
            if (drawY == V_LAST) begin
                trig      = 1'b1;
                trig_line = '0;
            end else if (!drawY[0] && (drawY <= LAST_TRIG_Y)) begin
                trig      = 1'b1;
                trig_line = LINE_W'(drawY[9:1]) + LINE_W'(1);
            end
        end
    end

    // The bank about to be displayed must be complete at the start of each
    // even visible row.
    assign line_late = (drawX == 10'd0) && !drawY[0] && (drawY < OUT_H) && !done[drawY[1]];

    // -----------------------------------------------------------------------
    // Fetch FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_25mhz) begin
        // NOTE: sequential blocks use non-blocking assignments so that every
        // register samples pre-edge values regardless of statement order.
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Fetch FSM: next state. A trigger always (re)starts a fetch, even one in
    // progress; the abandoned line is reported through underrun.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (trig) state_next = S_FETCH;
            end
            S_FETCH: begin
                if (trig)                             state_next = S_FETCH;
                else if (grant_rd && fx == LAST_IDX)  state_next = S_DRAIN;
            end
            S_DRAIN: begin
                state_next = trig ? S_FETCH : S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Fetch FSM: outputs
    always_comb begin
        fetch_req  = (state == S_FETCH);
        fetch_done = (state == S_DRAIN) && !trig;
        abandon    = trig && (state != S_IDLE);
    end

    // -----------------------------------------------------------------------
    // Port arbitration. The writer wins a contested cycle unless the fetch has
    // already been refused WAIT_LIMIT times in a row. Grants are masked in
    // reset so the port is quiet even before the first reset edge.
    // -----------------------------------------------------------------------
    always_comb begin
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        if (reset_n) begin
            if (fetch_req && (!wr_req || (wait_cnt >= WAIT_LIMIT))) begin
                grant_rd = 1'b1;
            end else if (wr_req) begin
                grant_wr = 1'b1;
            end
        end
    end

    // fy*320 as two shifts; fits 17 bits for every fy below 240
    assign line_base = (17'(fy) << 8) + (17'(fy) << 6);
    assign rd_addr   = line_base + 17'(fx);

    assign wr_ack   = grant_wr;
    assign fb_we    = grant_wr;
    assign fb_addr  = grant_wr ? wr_addr : (grant_rd ? rd_addr : addr_hold);
    assign fb_wdata = grant_wr ? wr_data : wdata_hold;

    // -----------------------------------------------------------------------
    // Fetch datapath, starvation counter, completion flags and underrun
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_25mhz) begin
        if (!reset_n) begin
            fx         <= '0;
            fy         <= '0;
            fill_bank  <= 1'b0;
            wait_cnt   <= '0;
            done       <= '0;
            underrun   <= 1'b0;
            tag_valid  <= 1'b0;
            tag_bank   <= 1'b0;
            tag_idx    <= '0;
            addr_hold  <= '0;
            wdata_hold <= '0;
        end else begin
            addr_hold <= fb_addr;
            if (grant_wr) wdata_hold <= wr_data;

            if (trig) begin
                fx              <= '0;
                fy              <= trig_line;
                fill_bank       <= trig_line[0];
                done[trig_line[0]] <= 1'b0;
            end else if (grant_rd) begin
                fx <= fx + IDX_W'(1);
            end

            // The drain cycle writes the last word, so the bank is complete
            // from the next cycle on.
            if (fetch_done) done[fill_bank] <= 1'b1;

            // Counts consecutive refusals; saturates so a large MAX_WAIT
            // cannot wrap it back to zero.
            if (fetch_req) begin
                if (grant_rd)               wait_cnt <= '0;
                else if (wait_cnt != 4'hF)  wait_cnt <= wait_cnt + 4'd1;
            end

            tag_valid <= grant_rd;
            tag_bank  <= fill_bank;
            tag_idx   <= fx;

            if (abandon || line_late) underrun <= 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Line-buffer write: read data returns one cycle after its address, and
    // the tag says which bank and index it belongs to.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_25mhz) begin
        // NOTE: line-buffer storage is deliberately not reset; every entry is
        // rewritten by a fetch before it is displayed, and a reset port would
        // stop the arrays mapping onto block RAM.
        if (tag_valid) begin
            if (tag_bank) bank1[tag_idx] <= fb_rdata;
            else          bank0[tag_idx] <= fb_rdata;
        end
    end

    // -----------------------------------------------------------------------
    // Display path: one-cycle registered read of the display bank. The index
    // is forced to 0 outside the active area so it never leaves 0..SRC_W-1.
    // -----------------------------------------------------------------------
    assign visible  = (drawX < OUT_W) && (drawY < OUT_H);
    assign disp_idx = visible ? drawX[IDX_W:1] : '0;

    always_ff @(posedge clk_25mhz) begin
        rd0 <= bank0[disp_idx];
        rd1 <= bank1[disp_idx];
    end

    always_ff @(posedge clk_25mhz) begin
        if (!reset_n) begin
            vis_q  <= 1'b0;
            bank_q <= 1'b0;
        end else begin
            vis_q  <= visible;
            bank_q <= drawY[1];
        end
    end

    assign pix        = vis_q ? (bank_q ? rd1 : rd0) : 12'd0;
    assign pixel_R_in = pix[11:8];
    assign pixel_G_in = pix[7:4];
    assign pixel_B_in = pix[3:0];

endmodule
